// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file: default geometry,
// PC step sizes, and the location of the PC within the register index space.
package regfile_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_PC_INC      = 4;
  localparam int DEFAULT_PC_READ_OFS = 8;

  // The PC always occupies the highest architectural index.
  function automatic int pc_index(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/reg_word.sv
// One general-purpose register with per-byte write enables and synchronous reset.
module reg_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH/8-1:0] byte_en,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (byte_en[b]) q[8*b +: 8] <= d[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Multi-ported register file with byte-masked writes, write-first read bypass,
// and an auto-incrementing PC living at the top index.
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PC_INC      = DEFAULT_PC_INC,
  parameter int PC_READ_OFS = DEFAULT_PC_READ_OFS,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEnable,
  input  logic [AW-1:0]      writeAddr,
  input  logic [WIDTH-1:0]   writeData,
  input  logic [WIDTH/8-1:0] byteEnable,
  input  logic [AW-1:0]      readAddr1,
  input  logic [AW-1:0]      readAddr2,
  output logic [WIDTH-1:0]   readData1,
  output logic [WIDTH-1:0]   readData2,
  input  logic               pcStall,
  output logic [WIDTH-1:0]   pcOut
);

  localparam int NB     = WIDTH / 8;
  localparam int PC_IDX = pc_index(DEPTH);

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [NB-1:0]    be);
    logic [WIDTH-1:0] result;
    result = old_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_read;
  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] write_merged;
  logic             write_ok;
  logic             pc_write;

  // words[] presents every index uniformly, with the PC slotted in at the top.
  assign words[PC_IDX] = pc;
  assign write_ok      = writeEnable && (int'(writeAddr) < DEPTH);
  assign write_merged  = merge_bytes(words[writeAddr], writeData, byteEnable);
  assign pc_write      = write_ok && (int'(writeAddr) == PC_IDX) && (|byteEnable);
  assign pc_read       = pc + WIDTH'(PC_READ_OFS);
  assign pcOut         = pc;

  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk     (clk),
      .reset   (reset),
      .en      (write_ok && (int'(writeAddr) == i)),
      .byte_en (byteEnable),
      .d       (writeData),
      .q       (words[i])
    );
  end

  // A PC write acts as a branch and wins over both increment and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (pc_write) begin
      pc <= write_merged;
    end else if (!pcStall) begin
      pc <= pc + WIDTH'(PC_INC);
    end
  end

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = readAddr1;
  assign rd_addr[1] = readAddr2;

  // The PC index is checked before the bypass so it never sees in-flight writes.
  for (genvar p = 0; p < 2; p++) begin : g_read
    assign rd_data[p] = (int'(rd_addr[p]) >= DEPTH)              ? '0 :
                        (int'(rd_addr[p]) == PC_IDX)             ? pc_read :
                        (writeEnable && rd_addr[p] == writeAddr) ? write_merged :
                                                                   words[rd_addr[p]];
  end

  assign readData1 = rd_data[0];
  assign readData2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector tables for the
// PC/bypass/reset corner cases, then randomized traffic against a reference model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [3:0]  writeAddr;
  logic [31:0] writeData;
  logic [3:0]  byteEnable;
  logic [3:0]  readAddr1;
  logic [3:0]  readAddr2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        pcStall;
  logic [31:0] pcOut;

  int vectors;
  int miscompares;

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .byteEnable  (byteEnable),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .readData1   (readData1),
    .readData2   (readData2),
    .pcStall     (pcStall),
    .pcOut       (pcOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        stall;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic [31:0] expPc;
  } vec_t;

  vec_t tbl [20];
  vec_t handTbl [4];

  // Reference state: fifteen general registers plus the PC.
  logic [31:0] modelRegs [15];
  logic [31:0] modelPc;

  function automatic logic [31:0] byteMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] addr, input logic we,
                                            input logic [3:0] waddr, input logic [31:0] wdata,
                                            input logic [3:0] be);
    logic [31:0] m;
    m = byteMask(be);
    if (addr == 4'd15) return modelPc + 32'd8;
    if (we && addr == waddr) return (modelRegs[addr] & ~m) | (wdata & m);
    return modelRegs[addr];
  endfunction

  task automatic modelStep();
    logic [31:0] m;
    m = byteMask(byteEnable);
    if (reset) begin
      for (int i = 0; i < 15; i++) modelRegs[i] = 32'd0;
      modelPc = 32'd0;
    end else begin
      if (writeEnable && byteEnable != 4'd0 && writeAddr == 4'd15)
        modelPc = (modelPc & ~m) | (writeData & m);
      else if (!pcStall)
        modelPc = modelPc + 32'd4;
      if (writeEnable && writeAddr < 4'd15)
        modelRegs[writeAddr] = (modelRegs[writeAddr] & ~m) | (writeData & m);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    writeEnable = v.we;
    writeAddr   = v.waddr;
    writeData   = v.wdata;
    byteEnable  = v.be;
    readAddr1   = v.ra1;
    readAddr2   = v.ra2;
    pcStall     = v.stall;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, " pcOut"}, pcOut, v.expPc);
    checkOutput({tag, " rd1"}, readData1, v.expRd1);
    checkOutput({tag, " rd2"}, readData2, v.expRd2);
    modelStep();
  endtask

  initial begin
    vec_t rv;
    vectors     = 0;
    miscompares = 0;

    //           rst  we   waddr  wdata         be       ra1    ra2    stall expRd1        expRd2        expPc
    tbl[0]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h8,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'hC,        32'h0,        32'h4};
    tbl[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h10,       32'h0,        32'h8};
    tbl[3]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h14,       32'h0,        32'hC};
    tbl[4]  = '{1'b0, 1'b1, 4'd3,  32'hDEADBEEF, 4'b1111, 4'd3,  4'd3,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h10};
    tbl[5]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd3,  4'd15, 1'b0, 32'hDEADBEEF, 32'h1C,       32'h14};
    tbl[6]  = '{1'b0, 1'b1, 4'd3,  32'h11223344, 4'b0101, 4'd3,  4'd4,  1'b0, 32'hDE22BE44, 32'h0,        32'h18};
    tbl[7]  = '{1'b0, 1'b1, 4'd3,  32'hFFFFFFFF, 4'b0000, 4'd3,  4'd15, 1'b0, 32'hDE22BE44, 32'h24,       32'h1C};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd3,  4'd3,  1'b0, 32'hDE22BE44, 32'hDE22BE44, 32'h20};
    tbl[9]  = '{1'b0, 1'b1, 4'd15, 32'h100,      4'b1111, 4'd15, 4'd0,  1'b1, 32'h2C,       32'h0,        32'h24};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b1, 32'h108,      32'h0,        32'h100};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b1, 32'h108,      32'h0,        32'h100};
    tbl[12] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h108,      32'h0,        32'h100};
    tbl[13] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h10C,      32'h0,        32'h104};
    tbl[14] = '{1'b0, 1'b1, 4'd15, 32'hFFFFFFFC, 4'b1111, 4'd15, 4'd0,  1'b0, 32'h110,      32'h0,        32'h108};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h4,        32'h0,        32'hFFFFFFFC};
    tbl[16] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd0,  1'b0, 32'h8,        32'h0,        32'h0};
    tbl[17] = '{1'b1, 1'b1, 4'd5,  32'h55,       4'b1111, 4'd3,  4'd15, 1'b0, 32'hDE22BE44, 32'hC,        32'h4};
    tbl[18] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd5,  4'd3,  1'b0, 32'h0,        32'h0,        32'h0};
    tbl[19] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd5,  1'b0, 32'hC,        32'h0,        32'h4};

    handTbl[0] = '{1'b0, 1'b1, 4'd15, 32'h12345678, 4'b0001, 4'd15, 4'd2,  1'b0, 32'h8,  32'h0,  32'h0};
    handTbl[1] = '{1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 4'b0000, 4'd15, 4'd15, 1'b1, 32'h80, 32'h80, 32'h78};
    handTbl[2] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd2,  1'b0, 32'h80, 32'h0,  32'h78};
    handTbl[3] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd2,  1'b0, 32'h84, 32'h0,  32'h7C};

    reset       = 1'b1;
    writeEnable = 1'b0;
    writeAddr   = 4'd0;
    writeData   = 32'd0;
    byteEnable  = 4'd0;
    readAddr1   = 4'd0;
    readAddr2   = 4'd0;
    pcStall     = 1'b0;
    repeat (2) @(posedge clk);
    modelStep();

    for (int i = 0; i < 20; i++) runVector(tbl[i], $sformatf("tbl%0d", i));

    // Randomized traffic with occasional resets, checked against the model.
    for (int n = 0; n < 400; n++) begin
      rv.rst   = ($urandom_range(0, 49) == 0);
      rv.we    = $urandom_range(0, 1) == 1;
      rv.waddr = 4'($urandom_range(0, 15));
      rv.wdata = $urandom;
      rv.be    = 4'($urandom_range(0, 15));
      rv.ra1   = 4'($urandom_range(0, 15));
      rv.ra2   = ($urandom_range(0, 3) == 0) ? rv.waddr : 4'($urandom_range(0, 15));
      rv.stall = ($urandom_range(0, 3) == 0);
      applyStimulus(rv);
      checkOutput($sformatf("rand%0d pcOut", n), pcOut, modelPc);
      if (!rv.rst) begin
        checkOutput($sformatf("rand%0d rd1", n), readData1,
                    modelRead(rv.ra1, rv.we, rv.waddr, rv.wdata, rv.be));
        checkOutput($sformatf("rand%0d rd2", n), readData2,
                    modelRead(rv.ra2, rv.we, rv.waddr, rv.wdata, rv.be));
      end
      modelStep();
    end

    // Partial-byte branch, then a masked-off PC write during a stall.
    rv = '{1'b1, 1'b0, 4'd0, 32'h0, 4'b0000, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    applyStimulus(rv);
    modelStep();
    for (int i = 0; i < 4; i++) runVector(handTbl[i], $sformatf("hand%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
